maze_path_checker: RTL

MAZE_PATH_CHECKER -- requirements
Module: maze_path_checker

---
 rtl/maze_pkg.sv | 42 ++++
 rtl/maze_path_checker_if.sv | 30 +++
 rtl/maze_step.sv | 39 +++
 rtl/maze_path_checker.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared move codes, error codes, FSM states and widths for the maze path checker.
// Pure type/constant package; no latency, no flow control.
package maze_pkg;

    localparam int COORD_W = 4;
    localparam int STEP_W  = 8;

    localparam logic [COORD_W-1:0] GRID_MIN = 4'd0;
    localparam logic [COORD_W-1:0] GRID_MAX = 4'd15;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [STEP_W-1:0]  step_t;

    typedef enum logic [1:0] {
        MV_LEFT  = 2'b00,
        MV_UP    = 2'b01,
        MV_RIGHT = 2'b10,
        MV_DOWN  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_WALL = 2'b01,
        ERR_OOB  = 2'b10,
        ERR_END  = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        READ      = 3'd2,
        CHECK     = 3'd3,
        PASS      = 3'd4,
        FAIL      = 3'd5
    } state_t;

    function automatic logic at_cell(input coord_t x, input coord_t y,
                                     input coord_t cx, input coord_t cy);
        return (x == cx) && (y == cy);
    endfunction

endpackage

// File: rtl/maze_path_checker_if.sv
// Move stream, maze memory port and verdict signals of the path checker.
// master = move sender plus maze memory; slave = the checker.
interface maze_path_checker_if;
    import maze_pkg::*;

    logic       Start;
    logic [1:0] Move;
    logic       Move_valid;
    logic       Move_ready;
    logic       Path_end;
    coord_t     X;
    coord_t     Y;
    logic       RD;
    logic       D_out;
    logic       Check_done;
    logic       Path_ok;
    step_t      Step_count;
    logic [1:0] Err_code;

    modport master (
        output Start, Move, Move_valid, Path_end, D_out,
        input  Move_ready, X, Y, RD, Check_done, Path_ok, Step_count, Err_code
    );

    modport slave (
        input  Start, Move, Move_valid, Path_end, D_out,
        output Move_ready, X, Y, RD, Check_done, Path_ok, Step_count, Err_code
    );

endinterface

// File: rtl/maze_step.sv
// Next-cell and grid-bounds computation for one move on the 16x16 maze.
// Purely combinational; an off-grid move reports oob and leaves the cell unchanged.
module maze_step
    import maze_pkg::*;
(
    input  coord_t     X,
    input  coord_t     Y,
    input  logic [1:0] Move,
    output coord_t     nX,
    output coord_t     nY,
    output logic       oob
);

    always_comb begin
        nX  = X;
        nY  = Y;
        oob = 1'b0;
        case (move_t'(Move))
            MV_LEFT: begin
                if (X == GRID_MIN) oob = 1'b1;
                else               nX  = X - 4'd1;
            end
            MV_UP: begin
                if (Y == GRID_MIN) oob = 1'b1;
                else               nY  = Y - 4'd1;
            end
            MV_RIGHT: begin
                if (X == GRID_MAX) oob = 1'b1;
                else               nX  = X + 4'd1;
            end
            MV_DOWN: begin
                if (Y == GRID_MAX) oob = 1'b1;
                else               nY  = Y + 4'd1;
            end
            default: oob = 1'b0;
        endcase
    end

endmodule

// File: rtl/maze_path_checker.sv
// Walks a move stream through a 16x16 maze, reading each new cell and issuing a pass/fail verdict.
// 3 cycles per accepted move; Move_ready is high only while waiting for a move.
module maze_path_checker
    import maze_pkg::*;
#(
    parameter coord_t START_X   = 4'd0,
    parameter coord_t START_Y   = 4'd0,
    parameter coord_t GOAL_X    = 4'd15,
    parameter coord_t GOAL_Y    = 4'd15,
    parameter step_t  MAX_STEPS = 8'd255
) (
    input logic              clk,
    input logic              rst,
    maze_path_checker_if.slave io
);

    state_t state_q, state_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    step_t  cnt_q, cnt_d;
    err_t   err_q, err_d;
    logic   end_q, end_d;
    logic   rd_q, rd_d;
    logic   rdy_q, rdy_d;
    logic   done_q, done_d;
    logic   ok_q, ok_d;

    coord_t nx;
    coord_t ny;
    logic   oob;
    logic   at_goal;

    maze_step u_step (
        .X   (x_q),
        .Y   (y_q),
        .Move(io.Move),
        .nX  (nx),
        .nY  (ny),
        .oob (oob)
    );

    assign at_goal = at_cell(x_q, y_q, GOAL_X, GOAL_Y);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        end_d   = end_q;

        case (state_q)
            IDLE, PASS, FAIL: begin
                if (io.Start) begin
                    state_d = WAIT_MOVE;
                    x_d     = START_X;
                    y_d     = START_Y;
                    cnt_d   = '0;
                    err_d   = ERR_NONE;
                    end_d   = 1'b0;
                end
            end
            WAIT_MOVE: begin
                // A move always wins over Path_end; the end is remembered and judged after CHECK.
                if (io.Move_valid) begin
                    if (cnt_q == MAX_STEPS) begin
                        state_d = FAIL;
                        err_d   = ERR_END;
                    end else if (oob) begin
                        state_d = FAIL;
                        err_d   = ERR_OOB;
                    end else begin
                        state_d = READ;
                        x_d     = nx;
                        y_d     = ny;
                        cnt_d   = cnt_q + 1'b1;
                        end_d   = io.Path_end;
                    end
                end else if (io.Path_end) begin
                    state_d = at_goal ? PASS : FAIL;
                    err_d   = at_goal ? ERR_NONE : ERR_END;
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (io.D_out) begin
                    state_d = FAIL;
                    err_d   = ERR_WALL;
                end else if (end_q) begin
                    state_d = at_goal ? PASS : FAIL;
                    err_d   = at_goal ? ERR_NONE : ERR_END;
                end else begin
                    state_d = WAIT_MOVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state so they line up with it.
        rdy_d  = (state_d == WAIT_MOVE);
        rd_d   = (state_d == READ);
        done_d = (state_d == PASS) || (state_d == FAIL);
        ok_d   = (state_d == PASS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
            end_q   <= 1'b0;
            rd_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            end_q   <= end_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    assign io.X          = x_q;
    assign io.Y          = y_q;
    assign io.RD         = rd_q;
    assign io.Move_ready = rdy_q;
    assign io.Check_done = done_q;
    assign io.Path_ok    = ok_q;
    assign io.Step_count = cnt_q;
    assign io.Err_code   = err_q;

endmodule
